gat_bram_load_bridge: RTL and testbench
=======================================

# gat_bram_load_bridge

Multi-channel host-to-core BRAM load bridge for the GAT accelerator. It sits between the AXI BRAM-controller ports of the block design and the core's on-chip BRAMs (H data, node info, weights, subgraph index, and later layers). It assembles 32-bit host beats into entries up to `DATA_W` bits wide, converts byte addresses to entry addresses, and counts committed entries per channel. It raises per-channel and global load-done status, replacing the host-driven `*_load_done` strobes with hardware-checked completion.

## Interface

Parameters:
- `NUM_CH`, 4, number of independent load channels.
- `TOP_WIDTH`, 32, host beat width; fixed at 32.
- `DATA_W`, 64, core entry width; `1..TOP_WIDTH*BEATS`. Bits above `DATA_W` in the last beat are dropped.
- `BEATS`, 2, beats per entry; must be a power of two, ≥1.
- `BEAT_W`, `$clog2(BEATS)`, beat-select field width; 0 when `BEATS==1`.
- `ADDR_W`, 18, core entry-address width.
- `HADDR_W`, `ADDR_W+BEAT_W+2`, host byte-address width.

Ports (vectors are flattened; channel `c` occupies slice `c`):
- `clk`  in  1  core clock; the block has one clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `host_din`  in  NUM_CH*TOP_WIDTH  host write data.
- `host_ena`  in  NUM_CH  host enable.
- `host_wea`  in  NUM_CH  host write strobe; a beat is taken when `ena&wea`.
- `host_addra`  in  NUM_CH*HADDR_W  host byte address.
- `cfg_num_entries`  in  NUM_CH*(ADDR_W+1)  expected entry count; 0 means host-terminated.
- `load_start`  in  NUM_CH  one-cycle pulse that restarts the channel.
- `host_load_done`  in  NUM_CH  one-cycle pulse for host-forced completion.
- `core_wea`  out  NUM_CH  core write strobe.
- `core_addra`  out  NUM_CH*ADDR_W  core entry address.
- `core_din`  out  NUM_CH*DATA_W  core entry data.
- `load_done`  out  NUM_CH  channel is complete.
- `all_load_done`  out  1  AND of `load_done`.
- `seq_err`  out  NUM_CH  sticky: an entry was committed with missing beats.
- `ovf_err`  out  NUM_CH  sticky: a beat arrived while the channel was in DONE.

## Operation

- Each channel has a state machine with states IDLE, LOAD and DONE. Reset state is IDLE.
- IDLE→LOAD: on the first accepted beat, or on `load_start`.
- LOAD→DONE: on the cycle the committed count reaches a nonzero `cfg_num_entries`, or on `host_load_done`.
- DONE→IDLE: on `load_start`.
- Address decode:
  - beat index = `addra[BEAT_W+1:2]`
  - entry address = `addra[HADDR_W-1:BEAT_W+2]`
  - `addra[1:0]` is ignored.
- An accepted beat writes slice `beat` of a per-channel assembly register and sets bit `beat` of a valid mask.
- A beat with index `BEATS-1` commits the entry:
  - core write of the assembled data, with the current beat merged in, at the entry address;
  - the count increments and the mask clears.
- If the mask is not all ones for beats `0..BEATS-2` at commit time, the entry is still written with stale slices and `seq_err` is set.
- With `BEATS==1`, every accepted beat commits.
- Beats accepted in DONE are dropped: no core write, and `ovf_err` is set.
- `load_start`:
  - clears the count, mask, `load_done`, `seq_err` and `ovf_err`;
  - goes to LOAD;
  - a beat in the same cycle is accepted after the clear.
- If `host_load_done` and a committing beat arrive in the same cycle, the beat commits first, then the channel enters DONE.
- The count does not deduplicate addresses. Rewrites count again.
- The count saturates at `2^(ADDR_W+1)-1`.

## Timing

- Commit latency: the core write is registered, so `core_wea`, `core_addra` and `core_din` assert 1 cycle after the committing host beat, for exactly 1 cycle.
- Back-to-back committing beats produce back-to-back core writes. Throughput is one entry per cycle per channel.
- `load_done` rises 2 cycles after the final committing beat: one cycle for the count, one for the state register.
- `load_done` rises 1 cycle after `host_load_done`. `all_load_done` follows combinationally.
- Reset values: all outputs 0, all state IDLE, counts 0. Reset mid-load discards the partial assembly.
- Channels are fully independent; there is no arbitration.

## Structure

- `gat_pkg` holds:
  - the `load_state_e` enum (IDLE/LOAD/DONE);
  - the `GAT_TOP_WIDTH=32` constant;
  - a `haddr_w()` function.
- The sub-module `gat_bram_load_ch` implements one channel (FSM, assembly, count). The top generates `NUM_CH` instances and the AND reduce.

## Test plan

- **Two-beat load.** `BEATS=2`, `cfg=3`, beats at byte addresses 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14 → core writes at entry addresses 0, 1, 2 with `{beat1,beat0}`. `load_done` rises 2 cycles after 0x14.
- **Missing beat.** Only beat 1 written at 0x0C → core write at address 1 with stale low half and `seq_err=1`. The count still increments.
- **Host-terminated load.** `cfg=0`, 5 entries written, then `host_load_done` → `load_done` rises 1 cycle later. A further beat gives no core write and `ovf_err=1`.
- **Simultaneous commit and done.** Committing beat and `host_load_done` in the same cycle → the core write occurs and the channel reaches DONE.
- **Restart and reset.** `load_start` in DONE with a beat in the same cycle → flags clear, count = 0 and the beat is accepted. Then assert `rst_n` low mid-load → all outputs 0 asynchronously.
- **Independent channels.** Four channels with `cfg` 1, 2, 3, 4 loaded concurrently → each `load_done` rises independently, and `all_load_done` rises only after channel 3 completes.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared types and helpers for the GAT accelerator host-to-core BRAM load path.
package gat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  localparam int GAT_TOP_WIDTH = 32;

  function automatic int haddr_w(input int addr_w, input int beats);
    return addr_w + $clog2(beats) + 2;
  endfunction

endpackage

// File: rtl/gat_bram_load_ch.sv
// One load channel: assembles host beats into core entries, counts commits and
// tracks IDLE/LOAD/DONE completion with sticky sequencing/overflow flags.
module gat_bram_load_ch
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH = GAT_TOP_WIDTH,
  parameter int DATA_W    = 64,
  parameter int BEATS     = 2,
  parameter int BEAT_W    = $clog2(BEATS),
  parameter int ADDR_W    = 18,
  parameter int HADDR_W   = ADDR_W + BEAT_W + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TOP_WIDTH-1:0] din_i,
  input  logic                 ena_i,
  input  logic                 wea_i,
  input  logic [HADDR_W-1:0]   addra_i,
  input  logic [ADDR_W:0]      cfg_i,
  input  logic                 load_start_i,
  input  logic                 host_load_done_i,
  output logic                 core_wea_o,
  output logic [ADDR_W-1:0]    core_addra_o,
  output logic [DATA_W-1:0]    core_din_o,
  output logic                 load_done_o,
  output logic                 seq_err_o,
  output logic                 ovf_err_o
);

  localparam int ASM_W = TOP_WIDTH * BEATS;
  localparam int SEL_W = (BEAT_W > 0) ? BEAT_W : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [BEATS-1:0] LAST_BIT = BEATS'(1) << (BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  load_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEATS-1:0]  mask_q, mask_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [DATA_W-1:0] cdin_q, cdin_d;
  logic              seq_q, seq_d;
  logic              ovf_q, ovf_d;

  logic              beat_v;
  logic [SEL_W-1:0]  beat;
  logic [ADDR_W-1:0] entry;
  logic [CNT_W-1:0]  cnt_base;
  logic              unused_lsb;

  generate
    if (BEAT_W == 0) begin : g_one_beat
      assign beat = '0;
    end else begin : g_multi_beat
      assign beat = addra_i[BEAT_W+1:2];
    end
  endgenerate

  assign beat_v     = ena_i & wea_i;
  assign entry      = addra_i[HADDR_W-1:BEAT_W+2];
  assign unused_lsb = ^addra_i[1:0];
  // Completion compares the count as registered before this cycle's commit,
  // which gives the two-cycle commit-to-done latency.
  assign cnt_base   = load_start_i ? '0 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    asm_d   = asm_q;
    wea_d   = 1'b0;
    caddr_d = caddr_q;
    cdin_d  = cdin_q;
    seq_d   = seq_q;
    ovf_d   = ovf_q;

    if (load_start_i) begin
      cnt_d   = '0;
      mask_d  = '0;
      seq_d   = 1'b0;
      ovf_d   = 1'b0;
      state_d = LOAD;
    end else if (state_q == IDLE && beat_v) begin
      state_d = LOAD;
    end

    if (beat_v) begin
      if (state_d == DONE) begin
        ovf_d = 1'b1;
      end else begin
        asm_d[int'(beat)*TOP_WIDTH +: TOP_WIDTH] = din_i;
        mask_d = mask_d | (BEATS'(1) << beat);
        if (int'(beat) == BEATS - 1) begin
          wea_d   = 1'b1;
          caddr_d = entry;
          cdin_d  = asm_d[DATA_W-1:0];
          if (!(&(mask_d | LAST_BIT))) seq_d = 1'b1;
          mask_d  = '0;
          if (cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
        end
      end
    end

    if (state_d == LOAD &&
        (host_load_done_i || (cfg_i != '0 && cnt_base == cfg_i))) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      asm_q   <= '0;
      wea_q   <= 1'b0;
      caddr_q <= '0;
      cdin_q  <= '0;
      seq_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      asm_q   <= asm_d;
      wea_q   <= wea_d;
      caddr_q <= caddr_d;
      cdin_q  <= cdin_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
    end
  end

  assign core_wea_o   = wea_q;
  assign core_addra_o = caddr_q;
  assign core_din_o   = cdin_q;
  assign load_done_o  = (state_q == DONE);
  assign seq_err_o    = seq_q;
  assign ovf_err_o    = ovf_q;

endmodule

// File: rtl/gat_bram_load_bridge.sv
// Multi-channel host-to-core BRAM load bridge: NUM_CH independent load channels
// plus the global load-done reduction.
module gat_bram_load_bridge
  import gat_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int TOP_WIDTH = GAT_TOP_WIDTH,
  parameter int DATA_W    = 64,
  parameter int BEATS     = 2,
  parameter int BEAT_W    = $clog2(BEATS),
  parameter int ADDR_W    = 18,
  parameter int HADDR_W   = haddr_w(ADDR_W, BEATS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*TOP_WIDTH-1:0] host_din,
  input  logic [NUM_CH-1:0]           host_ena,
  input  logic [NUM_CH-1:0]           host_wea,
  input  logic [NUM_CH*HADDR_W-1:0]   host_addra,
  input  logic [NUM_CH*(ADDR_W+1)-1:0] cfg_num_entries,
  input  logic [NUM_CH-1:0]           load_start,
  input  logic [NUM_CH-1:0]           host_load_done,
  output logic [NUM_CH-1:0]           core_wea,
  output logic [NUM_CH*ADDR_W-1:0]    core_addra,
  output logic [NUM_CH*DATA_W-1:0]    core_din,
  output logic [NUM_CH-1:0]           load_done,
  output logic                        all_load_done,
  output logic [NUM_CH-1:0]           seq_err,
  output logic [NUM_CH-1:0]           ovf_err
);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      gat_bram_load_ch #(
        .TOP_WIDTH (TOP_WIDTH),
        .DATA_W    (DATA_W),
        .BEATS     (BEATS),
        .BEAT_W    (BEAT_W),
        .ADDR_W    (ADDR_W),
        .HADDR_W   (HADDR_W)
      ) u_ch (
        .clk              (clk),
        .rst_n            (rst_n),
        .din_i            (host_din[c*TOP_WIDTH +: TOP_WIDTH]),
        .ena_i            (host_ena[c]),
        .wea_i            (host_wea[c]),
        .addra_i          (host_addra[c*HADDR_W +: HADDR_W]),
        .cfg_i            (cfg_num_entries[c*(ADDR_W+1) +: (ADDR_W+1)]),
        .load_start_i     (load_start[c]),
        .host_load_done_i (host_load_done[c]),
        .core_wea_o       (core_wea[c]),
        .core_addra_o     (core_addra[c*ADDR_W +: ADDR_W]),
        .core_din_o       (core_din[c*DATA_W +: DATA_W]),
        .load_done_o      (load_done[c]),
        .seq_err_o        (seq_err[c]),
        .ovf_err_o        (ovf_err[c])
      );
    end
  endgenerate

  assign all_load_done = &load_done;

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Directed bench for gat_bram_load_bridge with a per-cycle behavioural model.
module tb_gat_bram_load_bridge;

  localparam int NC = 4;
  localparam int DW = 64;
  localparam int AW = 18;
  localparam int HW = 21;
  localparam int CW = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC*32-1:0] host_din;
  logic [NC-1:0]    host_ena, host_wea, load_start, host_load_done;
  logic [NC*HW-1:0] host_addra;
  logic [NC*CW-1:0] cfg_num_entries;
  logic [NC-1:0]    core_wea, load_done, seq_err, ovf_err;
  logic [NC*AW-1:0] core_addra;
  logic [NC*DW-1:0] core_din;
  logic             all_load_done;

  int errors = 0;
  int checks = 0;

  gat_bram_load_bridge #(
    .NUM_CH(NC), .TOP_WIDTH(32), .DATA_W(DW), .BEATS(2), .BEAT_W(1),
    .ADDR_W(AW), .HADDR_W(HW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host_din(host_din), .host_ena(host_ena),
    .host_wea(host_wea), .host_addra(host_addra), .cfg_num_entries(cfg_num_entries),
    .load_start(load_start), .host_load_done(host_load_done), .core_wea(core_wea),
    .core_addra(core_addra), .core_din(core_din), .load_done(load_done),
    .all_load_done(all_load_done), .seq_err(seq_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_st  [NC];   // 0 idle, 1 loading, 2 done
  int          m_cnt [NC];
  logic [31:0] m_word[NC][2];
  bit          m_have[NC];   // low half written since last commit
  bit          m_wea [NC];
  logic [AW-1:0] m_addr[NC];
  logic [63:0] m_din [NC];
  bit          m_seq [NC];
  bit          m_ovf [NC];

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_st[c] = 0; m_cnt[c] = 0; m_have[c] = 0; m_wea[c] = 0;
      m_addr[c] = '0; m_din[c] = '0; m_seq[c] = 0; m_ovf[c] = 0;
      m_word[c][0] = '0; m_word[c][1] = '0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      bit bv; int b; logic [AW-1:0] e; logic [31:0] d; int cfg; int base;
      bv   = host_ena[c] & host_wea[c];
      b    = int'(host_addra[c*HW+2]);
      e    = host_addra[c*HW+3 +: AW];
      d    = host_din[c*32 +: 32];
      cfg  = int'(cfg_num_entries[c*CW +: CW]);
      base = load_start[c] ? 0 : m_cnt[c];
      m_wea[c] = 0;
      if (load_start[c]) begin
        m_cnt[c] = 0; m_have[c] = 0; m_seq[c] = 0; m_ovf[c] = 0; m_st[c] = 1;
      end else if (m_st[c] == 0 && bv) begin
        m_st[c] = 1;
      end
      if (bv) begin
        if (m_st[c] == 2) m_ovf[c] = 1;
        else begin
          m_word[c][b] = d;
          if (b == 0) m_have[c] = 1;
          else begin
            m_wea[c]  = 1;
            m_addr[c] = e;
            m_din[c]  = {m_word[c][1], m_word[c][0]};
            if (!m_have[c]) m_seq[c] = 1;
            m_have[c] = 0;
            if (m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
          end
        end
      end
      if (m_st[c] == 1 && (host_load_done[c] || (cfg != 0 && base == cfg))) m_st[c] = 2;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit all_d;
        all_d = 1;
        for (int c = 0; c < NC; c++) begin
          chk($sformatf("m ch%0d wea", c), 64'(core_wea[c]), 64'(m_wea[c]));
          if (m_wea[c]) begin
            chk($sformatf("m ch%0d addr", c), 64'(core_addra[c*AW +: AW]), 64'(m_addr[c]));
            chk($sformatf("m ch%0d din", c), core_din[c*DW +: DW], m_din[c]);
          end
          chk($sformatf("m ch%0d done", c), 64'(load_done[c]), 64'(m_st[c] == 2));
          chk($sformatf("m ch%0d seq", c), 64'(seq_err[c]), 64'(m_seq[c]));
          chk($sformatf("m ch%0d ovf", c), 64'(ovf_err[c]), 64'(m_ovf[c]));
          if (m_st[c] != 2) all_d = 0;
        end
        chk("m all_done", 64'(all_load_done), 64'(all_d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    host_ena = '0; host_wea = '0; load_start = '0; host_load_done = '0;
  endtask

  task automatic set_beat(input int c, input int addr, input logic [31:0] d);
    host_ena[c] = 1'b1;
    host_wea[c] = 1'b1;
    host_addra[c*HW +: HW] = HW'(addr);
    host_din[c*32 +: 32] = d;
  endtask

  task automatic do_beat(input int c, input int addr, input logic [31:0] d);
    set_beat(c, addr, d);
    tick();
    clr();
  endtask

  task automatic set_cfg(input int c, input int v);
    cfg_num_entries[c*CW +: CW] = CW'(v);
  endtask

  task automatic restart(input int c);
    load_start[c] = 1'b1;
    tick();
    clr();
  endtask

  initial begin
    clr();
    host_din = '0; host_addra = '0; cfg_num_entries = '0;
    repeat (2) tick();
    chk("reset wea", 64'(core_wea), 64'h0);
    chk("reset done", 64'(load_done), 64'h0);
    chk("reset all_done", 64'(all_load_done), 64'h0);
    chk("reset flags", 64'({seq_err, ovf_err}), 64'h0);
    chk("reset din", core_din[63:0], 64'h0);
    rst_n = 1'b1;
    tick();

    // two-beat load, cfg=3
    set_cfg(0, 3);
    do_beat(0, 'h00, 32'hA0A0_0000);
    do_beat(0, 'h04, 32'hA1A1_0001);
    chk("t1 wea0", 64'(core_wea[0]), 64'h1);
    chk("t1 addr0", 64'(core_addra[AW-1:0]), 64'h0);
    chk("t1 din0", core_din[63:0], 64'hA1A1_0001_A0A0_0000);
    do_beat(0, 'h08, 32'hB0B0_0002);
    do_beat(0, 'h0C, 32'hB1B1_0003);
    do_beat(0, 'h10, 32'hC0C0_0004);
    do_beat(0, 'h14, 32'hC1C1_0005);
    chk("t1 addr2", 64'(core_addra[AW-1:0]), 64'h2);
    chk("t1 din2", core_din[63:0], 64'hC1C1_0005_C0C0_0004);
    chk("t1 done early", 64'(load_done[0]), 64'h0);
    tick();
    chk("t1 done", 64'(load_done[0]), 64'h1);
    chk("t1 wea gone", 64'(core_wea[0]), 64'h0);

    // missing low beat, cfg=1
    set_cfg(0, 1);
    restart(0);
    chk("t2 done cleared", 64'(load_done[0]), 64'h0);
    do_beat(0, 'h0C, 32'hD1D1_0006);
    chk("t2 addr", 64'(core_addra[AW-1:0]), 64'h1);
    chk("t2 din stale", core_din[63:0], 64'hD1D1_0006_C0C0_0004);
    chk("t2 seq", 64'(seq_err[0]), 64'h1);
    tick();
    chk("t2 count done", 64'(load_done[0]), 64'h1);

    // host-terminated load
    set_cfg(0, 0);
    restart(0);
    for (int i = 0; i < 10; i++) do_beat(0, i * 4, 32'h3000_0000 + 32'(i));
    chk("t3 last addr", 64'(core_addra[AW-1:0]), 64'h4);
    chk("t3 last din", core_din[63:0], 64'h3000_0009_3000_0008);
    chk("t3 not done", 64'(load_done[0]), 64'h0);
    host_load_done[0] = 1'b1;
    tick();
    clr();
    chk("t3 done", 64'(load_done[0]), 64'h1);
    do_beat(0, 'h28, 32'hDEAD_BEEF);
    chk("t3 no write", 64'(core_wea[0]), 64'h0);
    chk("t3 ovf", 64'(ovf_err[0]), 64'h1);

    // commit and host_load_done together
    restart(0);
    do_beat(0, 'h00, 32'hE0E0_0000);
    set_beat(0, 'h04, 32'hE1E1_0001);
    host_load_done[0] = 1'b1;
    tick();
    clr();
    chk("t4 wea", 64'(core_wea[0]), 64'h1);
    chk("t4 din", core_din[63:0], 64'hE1E1_0001_E0E0_0000);
    chk("t4 done", 64'(load_done[0]), 64'h1);

    // restart from DONE with a beat in the same cycle
    do_beat(0, 'h08, 32'h0BAD_0BAD);
    chk("t5 ovf set", 64'(ovf_err[0]), 64'h1);
    set_cfg(0, 1);
    load_start[0] = 1'b1;
    set_beat(0, 'h00, 32'hF0F0_0000);
    tick();
    clr();
    chk("t5 ovf cleared", 64'(ovf_err[0]), 64'h0);
    chk("t5 done cleared", 64'(load_done[0]), 64'h0);
    do_beat(0, 'h04, 32'hF1F1_0001);
    chk("t5 din", core_din[63:0], 64'hF1F1_0001_F0F0_0000);
    chk("t5 no seq", 64'(seq_err[0]), 64'h0);
    tick();
    chk("t5 done", 64'(load_done[0]), 64'h1);

    // asynchronous reset mid-load
    set_cfg(0, 2);
    restart(0);
    do_beat(0, 'h00, 32'h1111_0000);
    do_beat(0, 'h04, 32'h1111_0001);
    do_beat(0, 'h08, 32'h2222_0000);
    rst_n = 1'b0;
    #1;
    chk("t5 rst wea", 64'(core_wea[0]), 64'h0);
    chk("t5 rst din", core_din[63:0], 64'h0);
    chk("t5 rst addr", 64'(core_addra[AW-1:0]), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    do_beat(0, 'h0C, 32'h2222_0001);
    chk("t5 partial dropped", 64'(seq_err[0]), 64'h1);

    // four independent channels, cfg 1..4
    rst_n = 1'b0;
    tick();
    for (int c = 0; c < NC; c++) set_cfg(c, c + 1);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      logic [NC-1:0] want;
      for (int c = 0; c < NC; c++)
        if (k < 2 * (c + 1)) set_beat(c, k * 4, 32'hC0DE_0000 | 32'(c << 8) | 32'(k));
      tick();
      clr();
      for (int c = 0; c < NC; c++) want[c] = (k >= 2 * c + 2);
      chk($sformatf("t6 done k%0d", k), 64'(load_done), 64'(want));
    end
    chk("t6 all early", 64'(all_load_done), 64'h0);
    tick();
    chk("t6 all done", 64'(all_load_done), 64'h1);
    chk("t6 done vec", 64'(load_done), 64'hF);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
